wb_slave_mux: RTL and testbench
===============================

Name: wb_slave_mux

Overview:
Parametrised Wishbone classic slave fabric that succeeds the single-slave top-level hookup. It decodes one upstream Wishbone slave port onto NUM_SLAVES downstream slave ports, such as the gpu and future accelerators, plus a local CSR window. It adds registered acks, decode-error responses, an optional ack timeout, and masked interrupt aggregation. It sits directly behind the user-project Wishbone port.

Parameters:
NUM_SLAVES, 2, number of downstream slave ports (1..15).
ADDR_W, 30, word-address width (byte address bits [31:2]).
DEC_LSB, 16, lowest address bit of the slave-index field.
IDX_W, $clog2(NUM_SLAVES+1), width of the slave-index field adr[DEC_LSB +: IDX_W].
TIMEOUT, 255, cycles to wait for a downstream ack before error completion (1..65535).
ERR_DATA, 32'hDEAD_BEEF, read data returned on decode error or timeout.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  synchronous active-low reset
wbs_cyc_i  in  1  upstream cycle
wbs_stb_i  in  1  upstream strobe
wbs_we_i  in  1  upstream write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  ADDR_W  word address
wbs_ack_o  out  1  registered ack
wbs_dat_o  out  32  registered read data
m_cyc_o  out  NUM_SLAVES  per-slave cycle
m_stb_o  out  NUM_SLAVES  per-slave strobe
m_we_o  out  1  shared write enable
m_sel_o  out  4  shared byte selects
m_adr_o  out  ADDR_W  shared address (full, unmodified)
m_dat_o  out  32  shared write data
m_ack_i  in  NUM_SLAVES  per-slave ack
m_dat_i  in  32*NUM_SLAVES  packed read data; slave k occupies [32k+31:32k]
irq_i  in  NUM_SLAVES  level interrupts from slaves
irq_o  out  1  OR of masked pending interrupts, registered

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-low on wb_rst_n_i and is sampled at the clock edge.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - STATUS = 0, IRQ_MASK = 0, timeout counter = 0.
  - Reset asserted mid-transaction drops m_cyc/m_stb the following cycle, and no ack is issued.
- Decode: idx = wbs_adr_i[DEC_LSB +: IDX_W].
  - idx < NUM_SLAVES: downstream slave.
  - idx == NUM_SLAVES: local CSR.
  - idx > NUM_SLAVES: decode error.
- FSM states: IDLE, WAIT, ACK.
  - IDLE, downstream access: on cyc & stb, latch idx, we, sel, adr and dat. Assert m_cyc_o[idx] and m_stb_o[idx] from the next cycle. Go to WAIT.
  - IDLE, CSR access or decode error: capture the response and go to ACK. Ack is high in the cycle after the strobe is sampled, giving 1-cycle latency.
  - WAIT, slave acks: on m_ack_i[idx], capture that slave's 32-bit read data, deassert m_cyc/m_stb next cycle, and go to ACK.
  - WAIT, upstream abort: if wbs_cyc_i falls, deassert downstream next cycle and return to IDLE with no ack.
  - ACK: wbs_ack_o = 1 for exactly one cycle, then IDLE.
  - Only one transaction is outstanding at a time; there is no pipelining.
- Downstream latency: upstream ack rises 1 cycle after the slave ack is sampled. Total = 2 + slave wait cycles.
- wbs_dat_o holds its last value except when loaded in the capture cycle. Write acks carry don't-care data.
- m_ack_i from any non-selected slave is ignored.
- Decode error: ack with wbs_dat_o = ERR_DATA. Set STATUS[1] and record idx in STATUS[15:8]. Writes are discarded.
- CSR map, word offset = adr[1:0]:
  - 0 STATUS: bit0 timeout sticky, bit1 decode-error sticky, [15:8] idx of last error. Writing 1 clears bit0/bit1 per sel[0]. A set event in the same cycle as a clear wins (stays set).
  - 1 IRQ_MASK: RW, bits [NUM_SLAVES-1:0], byte-enabled. Upper bits read 0.
  - 2 IRQ_PEND: RO, irq_i & IRQ_MASK.
  - 3 ID: RO, {16'h7452, 8'(NUM_SLAVES), 8'h01}.
  - Offsets above 3 alias mod 4. Writes to RO registers are acked and ignored.
- irq_o = |(irq_i & IRQ_MASK), registered, so it has 1-cycle latency.

Optional Feature:
WB_SLAVE_MUX_TIMEOUT_EN:
- Defined: a 16-bit counter resets on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT without an ack:
  - deassert downstream;
  - go to ACK with wbs_dat_o = ERR_DATA;
  - set STATUS[0] and record idx in STATUS[15:8].
- A slave ack in the same cycle the count reaches TIMEOUT takes priority and completes normally.
- Undefined: no counter; WAIT persists until ack or abort; STATUS[0] reads 0.

Test Plan:
- Reset: hold wb_rst_n_i=0 for 3 cycles with stb high -> all outputs 0. After release, read CSR 3 -> 32'h7452_0201 (NUM_SLAVES=2).
- Slave 1 read: adr = 1<<16, slave 1 acks 3 cycles after m_stb rises with data 32'hCAFE0001 -> only m_stb_o[1] asserted; wbs_ack_o one cycle later, single pulse, data 32'hCAFE0001; m_stb_o[0] stays 0.
- Decode error: read idx 3 -> ack at 1-cycle latency with data 32'hDEADBEEF; STATUS reads 32'h0000_0302. Write 1 to STATUS -> 32'h0000_0300.
- Timeout (macro defined, TIMEOUT=8): slave 0 never acks -> ack after 8 WAIT cycles with 32'hDEADBEEF, STATUS[0]=1. Repeat with the ack landing on cycle 8 -> normal data, STATUS[0] unchanged.
- Abort: drop wbs_cyc_i 2 cycles into WAIT -> m_cyc_o=0 next cycle, no wbs_ack_o. The next CSR read completes normally.
- IRQ: IRQ_MASK=2'b10, irq_i=2'b01 -> irq_o=0. Then irq_i=2'b11 -> irq_o=1 one cycle later, and IRQ_PEND reads 2'b10.

Source files
------------

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone classic 1-to-N slave fabric with CSR window, decode errors and irq aggregation.
// Optional downstream ack timeout is compiled in with `define WB_SLAVE_MUX_TIMEOUT_EN.
module wb_slave_mux #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W = 30,
  parameter int DEC_LSB = 16,
  parameter int IDX_W = $clog2(NUM_SLAVES + 1),
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [ADDR_W-1:0]        wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    m_cyc_o,
  output logic [NUM_SLAVES-1:0]    m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_sel_o,
  output logic [ADDR_W-1:0]        m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic [NUM_SLAVES-1:0]    m_ack_i,
  input  logic [32*NUM_SLAVES-1:0] m_dat_i,
  input  logic [NUM_SLAVES-1:0]    irq_i,
  output logic                     irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_q;
  logic [1:0] off;
  logic req, go_slave, go_csr, go_err, csr_wr;
  logic slv_ack, timeout_hit, load_dat, set_to, set_de, clr_to, clr_de;
  logic [31:0] slv_rdata, csr_rdata, dat_n;
  logic sto, sde;
  logic [7:0] err_idx;
  logic [NUM_SLAVES-1:0] irq_mask, mask_n;
  assign idx = wbs_adr_i[DEC_LSB +: IDX_W];
  assign off = wbs_adr_i[1:0];
  assign req = wbs_cyc_i & wbs_stb_i;
  assign go_slave = req && idx < IDX_W'(NUM_SLAVES);
  assign go_csr = req && idx == IDX_W'(NUM_SLAVES);
  assign go_err = req && idx > IDX_W'(NUM_SLAVES);
  assign csr_wr = state == S_IDLE && go_csr && wbs_we_i;
  always_comb begin
    slv_ack = 1'b0;
    slv_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      m_cyc_o[k] = state == S_WAIT && idx_q == IDX_W'(k);
      if (idx_q == IDX_W'(k)) begin
        slv_ack = m_ack_i[k];
        slv_rdata = m_dat_i[32*k +: 32];
      end
    end
  end
  assign m_stb_o = m_cyc_o;
  assign wbs_ack_o = state == S_ACK;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  logic [15:0] tcnt;
  always_ff @(posedge wb_clk_i)
    tcnt <= (!wb_rst_n_i || state != S_WAIT) ? 16'd0 : tcnt + 16'd1;
  // Fires on the TIMEOUT-th cycle spent in WAIT
  assign timeout_hit = state == S_WAIT && tcnt + 16'd1 == 16'(TIMEOUT);
`else
  assign timeout_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = go_slave ? S_WAIT : (go_csr || go_err) ? S_ACK : S_IDLE;
      S_WAIT:  state_n = !wbs_cyc_i ? S_IDLE : (slv_ack || timeout_hit) ? S_ACK : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i)
    state <= wb_rst_n_i ? state_n : S_IDLE;
  assign csr_rdata = off == 2'd0 ? {16'h0, err_idx, 6'h0, sde, sto} :
                     off == 2'd1 ? 32'(irq_mask) :
                     off == 2'd2 ? 32'(irq_i & irq_mask) :
                     {16'h7452, 8'(NUM_SLAVES), 8'h01};
  assign load_dat = (state == S_IDLE && (go_csr || go_err)) ||
                    (state == S_WAIT && wbs_cyc_i && (slv_ack || timeout_hit));
  assign dat_n = state == S_IDLE ? (go_csr ? csr_rdata : ERR_DATA) : slv_ack ? slv_rdata : ERR_DATA;
  assign set_de = state == S_IDLE && go_err;
  assign set_to = state == S_WAIT && wbs_cyc_i && !slv_ack && timeout_hit;
  assign clr_to = csr_wr && off == 2'd0 && wbs_sel_i[0] && wbs_dat_i[0];
  assign clr_de = csr_wr && off == 2'd0 && wbs_sel_i[0] && wbs_dat_i[1];
  always_comb begin
    mask_n = irq_mask;
    for (int k = 0; k < NUM_SLAVES; k++)
      if (csr_wr && off == 2'd1 && wbs_sel_i[k/8]) mask_n[k] = wbs_dat_i[k];
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      idx_q <= '0;
      m_we_o <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      wbs_dat_o <= '0;
      sto <= 1'b0;
      sde <= 1'b0;
      err_idx <= '0;
      irq_mask <= '0;
      irq_o <= 1'b0;
    end else begin
      if (state == S_IDLE && go_slave) begin
        idx_q <= idx;
        m_we_o <= wbs_we_i;
        m_sel_o <= wbs_sel_i;
        m_adr_o <= wbs_adr_i;
        m_dat_o <= wbs_dat_i;
      end
      if (load_dat) wbs_dat_o <= dat_n;
      // A set event outranks a simultaneous write-1-to-clear
      sto <= set_to | (sto & ~clr_to);
      sde <= set_de | (sde & ~clr_de);
      if (set_de) err_idx <= 8'(idx);
      else if (set_to) err_idx <= 8'(idx_q);
      irq_mask <= mask_n;
      irq_o <= |(irq_i & irq_mask);
    end
  end
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed table-driven bench for wb_slave_mux (NUM_SLAVES=2).
// Timeout sequences run only when WB_SLAVE_MUX_TIMEOUT_EN is defined (TIMEOUT=8).
module tb_wb_slave_mux;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam logic [29:0] A_CSR = 30'h20000;
  localparam logic [29:0] A_ERR = 30'h30000;
  localparam logic [29:0] A_S1 = 30'h10000;
  logic clk = 0, rst_n = 0;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic [29:0] adr = 0;
  logic ack;
  logic [1:0] m_cyc, m_stb, m_ack = 0, irq_i = 0;
  logic m_we;
  logic [3:0] m_sel;
  logic [29:0] m_adr;
  logic [31:0] m_dat_o;
  logic [63:0] m_dat_i = 0;
  logic irq_o;
  int checks = 0, failures = 0;
  wb_slave_mux #(.NUM_SLAVES(2), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel), .m_adr_o(m_adr),
    .m_dat_o(m_dat_o), .m_ack_i(m_ack), .m_dat_i(m_dat_i), .irq_i(irq_i), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we;
    logic [29:0] adr;
    logic [3:0] sel;
    logic [31:0] dat;
    logic chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic w, input logic [29:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat_i = d; lat = 0;
    do begin tick(); lat++; end while (!ack && lat < 400);
    rd = dat_o;
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask
  initial begin
    logic [31:0] rd;
    int lat;
    tv[0]  = '{1'b0, A_CSR | 30'd3, 4'hf, 32'h0, 1'b1, 32'h7452_0201};
    tv[1]  = '{1'b0, A_ERR, 4'hf, 32'h0, 1'b1, 32'hDEAD_BEEF};
    tv[2]  = '{1'b0, A_CSR, 4'hf, 32'h0, 1'b1, 32'h0000_0302};
    tv[3]  = '{1'b1, A_CSR, 4'h1, 32'h3, 1'b0, 32'h0};
    tv[4]  = '{1'b0, A_CSR, 4'hf, 32'h0, 1'b1, 32'h0000_0300};
    tv[5]  = '{1'b1, A_CSR | 30'd1, 4'h1, 32'h2, 1'b0, 32'h0};
    tv[6]  = '{1'b0, A_CSR | 30'd1, 4'hf, 32'h0, 1'b1, 32'h2};
    tv[7]  = '{1'b1, A_CSR | 30'd1, 4'h0, 32'hffff_ffff, 1'b0, 32'h0};
    tv[8]  = '{1'b0, A_CSR | 30'd1, 4'hf, 32'h0, 1'b1, 32'h2};
    tv[9]  = '{1'b1, A_CSR | 30'd3, 4'hf, 32'h0, 1'b0, 32'h0};
    tv[10] = '{1'b0, A_CSR | 30'd7, 4'hf, 32'h0, 1'b1, 32'h7452_0201};
    tv[11] = '{1'b0, A_CSR | 30'd5, 4'hf, 32'h0, 1'b1, 32'h2};
    tv[12] = '{1'b1, A_ERR, 4'hf, 32'h1234_5678, 1'b0, 32'h0};
    tv[13] = '{1'b0, A_CSR, 4'hf, 32'h0, 1'b1, 32'h0000_0302};
    tv[14] = '{1'b0, A_CSR | 30'd2, 4'hf, 32'h0, 1'b1, 32'h0};
    cyc = 1; stb = 1; adr = 30'h0;
    repeat (3) begin
      tick();
      chk("reset_outs", {ack, dat_o, m_cyc, m_stb, m_we, irq_o}, 64'h0);
      chk("reset_bus", {m_sel, m_adr, m_dat_o}, 64'h0);
    end
    cyc = 0; stb = 0; rst_n = 1;
    tick();
    foreach (tv[i]) begin
      xfer(tv[i].we, tv[i].adr, tv[i].sel, tv[i].dat, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_mcyc", i), m_cyc, 2'b00);
      if (tv[i].chk) chk($sformatf("vec%0d_dat", i), rd, tv[i].exp);
    end
    cyc = 1; stb = 1; we = 0; adr = A_S1; sel = 4'hf;
    m_dat_i = {32'hCAFE_0001, 32'h1111_1111};
    tick();
    chk("s1_stb", {m_cyc, m_stb}, 4'b1010);
    chk("s1_adr", m_adr, A_S1);
    m_ack = 2'b01;
    tick();
    chk("s1_ignore_other_ack", {ack, m_stb}, 3'b010);
    m_ack = 2'b00;
    tick();
    chk("s1_wait", {ack, m_stb}, 3'b010);
    m_ack = 2'b10;
    tick();
    m_ack = 2'b00;
    chk("s1_ack", {ack, m_stb}, 3'b100);
    chk("s1_dat", dat_o, 32'hCAFE_0001);
    cyc = 0; stb = 0;
    tick();
    chk("s1_single_pulse", ack, 1'b0);
    cyc = 1; stb = 1; adr = 30'h0;
    tick();
    chk("abort_stb", m_stb, 2'b01);
    tick();
    cyc = 0; stb = 0;
    tick();
    chk("abort_drop", {m_cyc, ack}, 3'b000);
    repeat (3) begin
      tick();
      chk("abort_no_ack", ack, 1'b0);
    end
    xfer(1'b0, A_CSR | 30'd3, 4'hf, 32'h0, rd, lat);
    chk("post_abort_lat", lat, 1);
    chk("post_abort_dat", rd, 32'h7452_0201);
    irq_i = 2'b01;
    tick();
    tick();
    chk("irq_masked", irq_o, 1'b0);
    irq_i = 2'b11;
    chk("irq_latency", irq_o, 1'b0);
    tick();
    chk("irq_set", irq_o, 1'b1);
    xfer(1'b0, A_CSR | 30'd2, 4'hf, 32'h0, rd, lat);
    chk("irq_pend", rd, 32'h2);
    irq_i = 2'b00;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    xfer(1'b1, A_CSR, 4'h1, 32'h3, rd, lat);
    xfer(1'b0, 30'h0, 4'hf, 32'h0, rd, lat);
    chk("to_lat", lat, 1 + TO);
    chk("to_dat", rd, 32'hDEAD_BEEF);
    xfer(1'b0, A_CSR, 4'hf, 32'h0, rd, lat);
    chk("to_status", rd, 32'h0000_0001);
    xfer(1'b1, A_CSR, 4'h1, 32'h3, rd, lat);
    cyc = 1; stb = 1; we = 0; adr = 30'h0;
    m_dat_i = {32'h0, 32'h5A5A_0000};
    repeat (TO) tick();
    chk("to_edge_pending", {ack, m_stb}, 3'b001);
    m_ack = 2'b01;
    tick();
    m_ack = 2'b00;
    chk("to_edge_ack", ack, 1'b1);
    chk("to_edge_dat", dat_o, 32'h5A5A_0000);
    cyc = 0; stb = 0;
    tick();
    xfer(1'b0, A_CSR, 4'hf, 32'h0, rd, lat);
    chk("to_edge_status", rd, 32'h0);
`endif
    cyc = 1; stb = 1; adr = 30'h0;
    tick();
    chk("midrst_start", m_cyc, 2'b01);
    rst_n = 0;
    tick();
    chk("midrst_drop", {m_cyc, ack}, 3'b000);
    cyc = 0; stb = 0; rst_n = 1;
    repeat (2) begin
      tick();
      chk("midrst_no_ack", {m_cyc, ack}, 3'b000);
    end
    xfer(1'b0, A_CSR | 30'd1, 4'hf, 32'h0, rd, lat);
    chk("midrst_mask_cleared", rd, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
